// File: rtl/mem_arbiter_if.sv
// Bundled requester (imem/dmem) and memory-port signals for mem_arbiter.
// The arbiter uses the slave modport; the requesters/memory side uses master.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_ren;
  logic [ADDR_W-1:0] imem_addr;
  logic              ihit;
  logic [31:0]       imem_load;

  logic              dmem_ren;
  logic              dmem_wen;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_store;
  logic [2:0]        dmem_width;
  logic              dhit;
  logic [31:0]       dmem_load;

  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_store;
  logic [2:0]        ram_width;
  logic [31:0]       ram_load;
  logic              ram_ready;

  logic              bus_err;

  modport slave (
    input  imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_store, dmem_width,
           ram_load, ram_ready,
    output ihit, imem_load, dhit, dmem_load, ram_ren, ram_wen, ram_addr, ram_store,
           ram_width, bus_err
  );

  modport master (
    output imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_store, dmem_width,
           ram_load, ram_ready,
    input  ihit, imem_load, dhit, dmem_load, ram_ren, ram_wen, ram_addr, ram_store,
           ram_width, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, with ready timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed data-over-instruction.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ADDR_W         = 32
) (
  input logic          clk,
  input logic          nrst,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IBUSY = 2'd1;
  localparam logic [1:0] DBUSY = 2'd2;

  localparam logic [2:0] WidthWord = 3'b010;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       store_q, store_d;
  logic [2:0]        width_q, width_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [31:0]       cnt_q, cnt_d;
`ifdef MEM_ARB_RR_EN
  logic              last_d_q, last_d_d;  // 1: data was granted last
`endif

  logic ibusy, dbusy, busy, timeout, done;
  logic dreq, ireq, pick_d;

  assign ibusy = (state_q == IBUSY);
  assign dbusy = (state_q == DBUSY);
  assign busy  = ibusy | dbusy;

  assign timeout = busy && !bus.ram_ready && (TIMEOUT_CYCLES != 0) &&
                   (cnt_q == TIMEOUT_CYCLES - 1);
  assign done    = busy && (bus.ram_ready || timeout);

  assign dreq = bus.dmem_ren | bus.dmem_wen;
  assign ireq = bus.imem_ren;

`ifdef MEM_ARB_RR_EN
  assign pick_d = dreq && (!ireq || !last_d_q);
`else
  assign pick_d = dreq;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    width_d = width_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    cnt_d   = cnt_q;
`ifdef MEM_ARB_RR_EN
    last_d_d = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_d) begin
          addr_d  = bus.dmem_addr;
          store_d = bus.dmem_store;
          width_d = bus.dmem_width;
          // A simultaneous read+write request is a write
          wen_d   = bus.dmem_wen;
          ren_d   = bus.dmem_ren & ~bus.dmem_wen;
          state_d = DBUSY;
`ifdef MEM_ARB_RR_EN
          last_d_d = 1'b1;
`endif
        end else if (ireq) begin
          addr_d  = bus.imem_addr;
          store_d = '0;
          width_d = WidthWord;
          ren_d   = 1'b1;
          wen_d   = 1'b0;
          state_d = IBUSY;
`ifdef MEM_ARB_RR_EN
          last_d_d = 1'b0;
`endif
        end
      end
      IBUSY, DBUSY: begin
        if (done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      width_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      width_q <= width_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`endif

  // Memory port shows only latched values, and only while a transaction is in flight
  always_comb begin
    bus.ram_ren   = busy & ren_q;
    bus.ram_wen   = busy & wen_q;
    bus.ram_addr  = busy ? addr_q  : '0;
    bus.ram_store = busy ? store_q : '0;
    bus.ram_width = busy ? width_q : '0;
    bus.ihit      = done & ibusy;
    bus.dhit      = done & dbusy;
    bus.imem_load = (ibusy && bus.ram_ready) ? bus.ram_load : '0;
    bus.dmem_load = (dbusy && bus.ram_ready) ? bus.ram_load : '0;
    bus.bus_err   = timeout;
  end

endmodule
